// File: rtl/pic_sequencer.sv
// pic_sequencer: phase generator, program counter, two-stage fetch/execute
// pipeline and hardware return stack for the PIC-style core.
// Optional build macro: PIC_SEQ_STACK_CHECK_EN enables the sticky stack
// overflow/underflow flags and makes a pop on an empty stack return address 0.
module pic_sequencer #(
    parameter int PHASES      = 4,
    parameter int PC_WIDTH    = 11,
    parameter int INSN_WIDTH  = 14,
    parameter int STACK_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic [INSN_WIDTH-1:0]              insn_in,
    input  logic [2:0]                         pc_op,
    input  logic [PC_WIDTH-1:0]                target,
    input  logic                               op_valid,
    output logic [PHASES-1:0]                  q,
    output logic [PC_WIDTH-1:0]                counter,
    output logic [INSN_WIDTH-1:0]              inst_reg,
    output logic                               flush,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_ptr,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    localparam int PH_W  = $clog2(PHASES);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_GOTO = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_SKIP = 3'd4
    } pc_op_e;

    logic [PH_W-1:0]     phase;
    pc_op_e              cap_op;
    logic [PC_WIDTH-1:0] cap_tgt;
    logic [PC_WIDTH-1:0] stk [STACK_DEPTH];
    logic [IDX_W-1:0]    top;
    logic [IDX_W-1:0]    top_inc;
    logic [IDX_W-1:0]    top_dec;
    logic [PC_WIDTH-1:0] pop_val;
    logic [PC_WIDTH-1:0] ctr_nxt;
    logic                do_push;
    logic                do_pop;
    logic                kill;
    logic                stk_full;
    logic                stk_empty;

    // Edge qualifiers: capture edge leaves phase PHASES-2, cycle end leaves PHASES-1
    wire adv     = !stall;
    wire at_last = (phase == PH_W'(PHASES - 1));
    wire at_capt = (phase == PH_W'(PHASES - 2));
    wire cyc_end = adv && at_last;

    assign q         = PHASES'(1) << phase;
    assign stk_full  = (stack_ptr == SP_W'(STACK_DEPTH));
    assign stk_empty = (stack_ptr == '0);
    assign top_inc   = (top == IDX_W'(STACK_DEPTH - 1)) ? '0 : top + IDX_W'(1);
    assign top_dec   = (top == '0) ? IDX_W'(STACK_DEPTH - 1) : top - IDX_W'(1);

`ifdef PIC_SEQ_STACK_CHECK_EN
    logic ovf_q;
    logic unf_q;

    // Empty pop is a detected error: send the core to the reset vector
    assign pop_val = stk_empty ? '0 : stk[top];

    // Sticky stack error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (cyc_end) begin
            if (do_push && stk_full) ovf_q <= 1'b1;
            if (do_pop && stk_empty) unf_q <= 1'b1;
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    // Unchecked build: an empty pop just reads whatever sits at the top index
    assign pop_val   = stk[top];
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    // Next PC and stack action for the captured op; any non-INC op kills the fetch
    always_comb begin
        ctr_nxt = counter + PC_WIDTH'(1);
        do_push = 1'b0;
        do_pop  = 1'b0;
        kill    = 1'b1;
        case (cap_op)
            OP_GOTO: ctr_nxt = cap_tgt;
            OP_CALL: begin
                ctr_nxt = cap_tgt;
                do_push = 1'b1;
            end
            OP_RET: begin
                ctr_nxt = pop_val;
                do_pop  = 1'b1;
            end
            OP_SKIP: ctr_nxt = counter + PC_WIDTH'(1);
            default: kill = 1'b0;
        endcase
    end

    // Phase counter, frozen by stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            phase <= '0;
        else if (adv)
            phase <= at_last ? '0 : phase + PH_W'(1);
    end

    // Latch the control op one phase before the cycle ends; undefined codes act as INC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_op  <= OP_INC;
            cap_tgt <= '0;
        end else if (adv && at_capt) begin
            cap_op  <= (op_valid && pc_op <= 3'd4) ? pc_op_e'(pc_op) : OP_INC;
            cap_tgt <= target;
        end
    end

    // PC update and fetch at cycle end; a taken transfer injects one NOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter  <= '0;
            inst_reg <= '0;
            flush    <= 1'b1;
        end else if (cyc_end) begin
            counter  <= ctr_nxt;
            inst_reg <= kill ? '0 : insn_in;
            flush    <= kill;
        end
    end

    // Circular return stack: full push overwrites the oldest, empty pop leaves count at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top       <= '0;
            stack_ptr <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
        end else if (cyc_end) begin
            if (do_push) begin
                stk[top_inc] <= counter;
                top          <= top_inc;
                if (!stk_full) stack_ptr <= stack_ptr + SP_W'(1);
            end else if (do_pop && !stk_empty) begin
                top       <= top_dec;
                stack_ptr <= stack_ptr - SP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pic_sequencer.sv
// Self-checking bench for pic_sequencer (default parameters). An instruction-level
// model pushes the expected post-cycle state to a scoreboard as each op is driven;
// the test tasks pop and compare once the cycle-end edge has passed.
module tb_pic_sequencer;

`ifdef PIC_SEQ_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [2:0] INC = 3'd0, GOTO = 3'd1, CALL = 3'd2, RET = 3'd3, SKIP = 3'd4;

    typedef struct packed {
        logic [10:0] counter;
        logic [13:0] inst;
        logic        flush;
        logic [3:0]  sp;
        logic        ovf;
        logic        unf;
    } snap_t;

    typedef struct packed {
        bit    known;
        snap_t s;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [13:0] insn_in;
    logic [2:0]  pc_op = 3'd0;
    logic [10:0] target = '0;
    logic        op_valid = 1'b0;
    logic [3:0]  q;
    logic [10:0] counter;
    logic [13:0] inst_reg;
    logic        flush;
    logic [3:0]  stack_ptr;
    logic        stack_ovf;
    logic        stack_unf;

    int checks = 0;
    int errors = 0;

    // Model state
    bit          use_const = 1'b1;
    logic [10:0] m_ctr;
    logic [10:0] m_stk[$];
    logic        m_ovf, m_unf;
    bit          m_known;
    snap_t       m_prev, m_cur;
    exp_t        sb[$];

    pic_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .insn_in(insn_in),
        .pc_op(pc_op), .target(target), .op_valid(op_valid), .q(q),
        .counter(counter), .inst_reg(inst_reg), .flush(flush),
        .stack_ptr(stack_ptr), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] insn_of(input logic [10:0] a);
        return use_const ? 14'h0123 : {3'b101, a};
    endfunction

    // Program memory
    assign insn_in = insn_of(counter);

    function automatic snap_t snap();
        return '{counter, inst_reg, flush, stack_ptr, stack_ovf, stack_unf};
    endfunction

    task automatic model_reset();
        m_ctr = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_known = 1'b1;
        m_cur = '{11'd0, 14'd0, 1'b1, 4'd0, 1'b0, 1'b0};
        m_prev = m_cur;
        sb.delete();
    endtask

    // Drive one instruction-cycle op and push its expected post-cycle state
    task automatic drive(input logic [2:0] op, input bit v, input logic [10:0] tgt);
        logic [2:0] eop;
        exp_t e;
        eop = (v && op <= 3'd4) ? op : INC;
        e.s.inst  = (eop == INC) ? insn_of(m_ctr) : 14'd0;
        e.s.flush = (eop != INC);
        case (eop)
            GOTO: m_ctr = tgt;
            CALL: begin
                if (m_stk.size() == 8) begin
                    void'(m_stk.pop_front());
                    if (CHK) m_ovf = 1'b1;
                end
                m_stk.push_back(m_ctr);
                m_ctr = tgt;
            end
            RET: begin
                if (m_stk.size() > 0) m_ctr = m_stk.pop_back();
                else if (CHK) begin
                    m_ctr = '0;
                    m_unf = 1'b1;
                end else m_known = 1'b0;
            end
            default: m_ctr = m_ctr + 11'd1;
        endcase
        e.known     = m_known;
        e.s.counter = m_ctr;
        e.s.sp      = 4'(m_stk.size());
        e.s.ovf     = m_ovf;
        e.s.unf     = m_unf;
        m_prev = m_cur;
        m_cur  = e.s;
        sb.push_back(e);
        pc_op = op;
        op_valid = v;
        target = tgt;
    endtask

    task automatic cycle_wait();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        snap_t o;
        use_const = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (snap() !== m_cur || q !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state got %h q=%b want %h q=0001", snap(), q, m_cur);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(INC, 1'b1, '0);
            for (int p = 1; p < 4; p++) begin
                @(posedge clk);
                #1;
                checks++;
                if (q !== 4'(1 << p)) begin
                    errors++;
                    $display("FAIL phase_q c%0d p%0d got %b want %b", c, p, q, 4'(1 << p));
                end
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = snap();
            checks++;
            if (o !== e.s || q !== 4'b0001) begin
                errors++;
                $display("FAIL inc_seq c%0d got %h q=%b want %h", c, o, q, e.s);
            end
        end
    endtask

    task automatic test_goto();
        exp_t e;
        logic [2:0]  ops[3] = '{INC, GOTO, INC};
        use_const = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 1'b1, 11'h2A0);
            cycle_wait();
            e = sb.pop_front();
            checks++;
            if (snap() !== e.s) begin
                errors++;
                $display("FAIL goto step%0d got %h want %h", i, snap(), e.s);
            end
        end
    endtask

    task automatic test_call_ret();
        exp_t e;
        logic [2:0]  ops[4]  = '{GOTO, CALL, INC, RET};
        logic [10:0] tgts[4] = '{11'h010, 11'h100, 11'h000, 11'h000};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 1'b1, tgts[i]);
            cycle_wait();
            e = sb.pop_front();
            checks++;
            if (snap() !== e.s) begin
                errors++;
                $display("FAIL call_ret step%0d got %h want %h", i, snap(), e.s);
            end
        end
    endtask

    task automatic test_stack_overflow();
        exp_t e;
        snap_t o;
        apply_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 9) drive(CALL, 1'b1, 11'h200 + 11'(i * 16));
            else       drive(RET, 1'b1, '0);
            cycle_wait();
            e = sb.pop_front();
            o = snap();
            checks++;
            if (e.known ? (o !== e.s)
                        : ({o.inst, o.flush, o.sp, o.ovf, o.unf} !==
                           {e.s.inst, e.s.flush, e.s.sp, e.s.ovf, e.s.unf})) begin
                errors++;
                $display("FAIL stack step%0d got %h want %h", i, o, e.s);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [2:0]  ops[5]  = '{GOTO, INC, INC, GOTO, SKIP};
        logic [10:0] tgts[5] = '{11'h7FE, 11'h0, 11'h0, 11'h7FF, 11'h0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 1'b1, tgts[i]);
            cycle_wait();
            e = sb.pop_front();
            checks++;
            if (snap() !== e.s) begin
                errors++;
                $display("FAIL wrap step%0d got %h want %h", i, snap(), e.s);
            end
        end
    endtask

    task automatic test_op_valid();
        exp_t e;
        logic [2:0] ops[3] = '{GOTO, 3'd5, 3'd7};
        bit         vs[3]  = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], vs[i], 11'h3C3);
            cycle_wait();
            e = sb.pop_front();
            checks++;
            if (snap() !== e.s) begin
                errors++;
                $display("FAIL op_valid step%0d got %h want %h", i, snap(), e.s);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        drive(CALL, 1'b1, 11'h155);
        repeat (2) @(posedge clk);
        #1;
        stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q !== 4'b0100 || snap() !== m_prev) begin
                errors++;
                $display("FAIL stall_hold k%0d got %h q=%b want %h q=0100", k, snap(), q, m_prev);
            end
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (q !== 4'b1000 || snap() !== m_prev) begin
            errors++;
            $display("FAIL stall_resume got %h q=%b want %h q=1000", snap(), q, m_prev);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (snap() !== e.s || q !== 4'b0001) begin
            errors++;
            $display("FAIL stall_end got %h q=%b want %h", snap(), q, e.s);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(CALL, 1'b1, 11'h0AA);
        cycle_wait();
        e = sb.pop_front();
        checks++;
        if (snap() !== e.s) begin
            errors++;
            $display("FAIL areset_pre got %h want %h", snap(), e.s);
        end
        drive(CALL, 1'b1, 11'h0BB);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (snap() !== m_cur || q !== 4'b0001) begin
            errors++;
            $display("FAIL areset_now got %h q=%b want %h q=0001", snap(), q, m_cur);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(INC, 1'b1, '0);
        cycle_wait();
        e = sb.pop_front();
        checks++;
        if (snap() !== e.s) begin
            errors++;
            $display("FAIL areset_after got %h want %h", snap(), e.s);
        end
    endtask

    initial begin
        test_reset();
        test_goto();
        test_call_ret();
        test_op_valid();
        test_stall();
        test_stack_overflow();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
